// File: rtl/kyogenrv_rst_seq_if.sv
// Sequencer-side signal bundle: raw button and watchdog kick in, sequenced reset,
// last reset cause and debounced button level out.
interface kyogenrv_rst_seq_if;
  logic       reset;
  logic       wdt_kick;
  logic       rst_n;
  logic [1:0] rst_cause;
  logic       btn_stable;

  modport master (
    output reset, wdt_kick,
    input  rst_n, rst_cause, btn_stable
  );

  modport slave (
    input  reset, wdt_kick,
    output rst_n, rst_cause, btn_stable
  );
endinterface

// File: rtl/kyogenrv_rst_seq.sv
// Reset sequencer for the Qsys system: synchronizes and debounces the board button and
// stretches reset release. Optional watchdog compiled in with RST_SEQ_WDT_EN.
//
// state   | meaning
// HOLD    | system held in reset, waiting for a released button
// STRETCH | button released, counting STRETCH_CYC cycles before release
// RUN     | system out of reset (rst_n=1)
module kyogenrv_rst_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 240000,
  parameter int STRETCH_CYC  = 1024,
  parameter int WDT_CYC      = 2**24
) (
  input logic              clk_riscv_i,
  input logic              pwrup_rst_n_i,
  kyogenrv_rst_seq_if.slave seq_if
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int ST_W = $clog2(STRETCH_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYC - 1);

  localparam logic [1:0] CAUSE_PWRUP  = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON = 2'b01;
  localparam logic [1:0] CAUSE_WDT    = 2'b10;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt_db_q, cnt_db_d;
  logic                   btn_stable_q, btn_stable_d;
  logic [ST_W-1:0]        cnt_st_q, cnt_st_d;
  logic [1:0]             cause_q, cause_d;
  logic                   rst_n_q, rst_n_d;
  logic                   sync_out;
  logic                   wdt_to;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Sync chain presets to "released" so power-up never looks like a button press.
  always_ff @(posedge clk_riscv_i or negedge pwrup_rst_n_i) begin
    if (!pwrup_rst_n_i) begin
      sync_q       <= '1;
      cnt_db_q     <= '0;
      btn_stable_q <= 1'b1;
      state_q      <= HOLD;
      cnt_st_q     <= '0;
      cause_q      <= CAUSE_PWRUP;
      rst_n_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], seq_if.reset};
      cnt_db_q     <= cnt_db_d;
      btn_stable_q <= btn_stable_d;
      state_q      <= state_d;
      cnt_st_q     <= cnt_st_d;
      cause_q      <= cause_d;
      rst_n_q      <= rst_n_d;
    end
  end

  always_comb begin
    btn_stable_d = btn_stable_q;
    cnt_db_d     = '0;
    if (sync_out != btn_stable_q) begin
      if (cnt_db_q == DB_LAST) begin
        btn_stable_d = sync_out;
      end else begin
        cnt_db_d = cnt_db_q + 1'b1;
      end
    end
  end

`ifdef RST_SEQ_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYC + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);

  logic [WDT_W-1:0] cnt_wdt_q, cnt_wdt_d;

  // A kick on the timeout cycle still counts as service.
  assign wdt_to = (state_q == RUN) && !seq_if.wdt_kick && (cnt_wdt_q == WDT_LAST);

  always_comb begin
    cnt_wdt_d = '0;
    if ((state_q == RUN) && !seq_if.wdt_kick) begin
      cnt_wdt_d = (cnt_wdt_q == WDT_LAST) ? cnt_wdt_q : cnt_wdt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_riscv_i or negedge pwrup_rst_n_i) begin
    if (!pwrup_rst_n_i) begin
      cnt_wdt_q <= '0;
    end else begin
      cnt_wdt_q <= cnt_wdt_d;
    end
  end
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = seq_if.wdt_kick;
  assign wdt_to          = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_st_d = cnt_st_q;
    cause_d  = cause_q;
    case (state_q)
      HOLD: begin
        cnt_st_d = '0;
        if (btn_stable_q) state_d = STRETCH;
      end
      STRETCH: begin
        if (!btn_stable_q) begin
          state_d  = HOLD;
          cnt_st_d = '0;
          cause_d  = CAUSE_BUTTON;
        end else if (cnt_st_q == ST_LAST) begin
          state_d  = RUN;
          cnt_st_d = '0;
        end else begin
          cnt_st_d = cnt_st_q + 1'b1;
        end
      end
      RUN: begin
        // Button wins when it coincides with a watchdog timeout.
        if (!btn_stable_q) begin
          state_d = HOLD;
          cause_d = CAUSE_BUTTON;
        end else if (wdt_to) begin
          state_d = HOLD;
          cause_d = CAUSE_WDT;
        end
      end
      default: begin
        state_d  = HOLD;
        cnt_st_d = '0;
      end
    endcase
    rst_n_d = (state_d == RUN);
  end

  assign seq_if.rst_n      = rst_n_q;
  assign seq_if.rst_cause  = cause_q;
  assign seq_if.btn_stable = btn_stable_q;

endmodule

// File: tb/tb_kyogenrv_rst_seq.sv
// Directed bench for kyogenrv_rst_seq with short sim parameters; watchdog scenarios
// are exercised when RST_SEQ_WDT_EN is defined.
module tb_kyogenrv_rst_seq;

  logic clk = 1'b0;
  logic pwrup_rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic saw_low;
  logic saw_wdt;

  kyogenrv_rst_seq_if seq_if ();

  kyogenrv_rst_seq #(
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(8),
    .STRETCH_CYC (16),
    .WDT_CYC     (64)
  ) dut (
    .clk_riscv_i  (clk),
    .pwrup_rst_n_i(pwrup_rst_n),
    .seq_if       (seq_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    pwrup_rst_n        = 1'b1;
    seq_if.reset       = 1'b1;
    seq_if.wdt_kick    = 1'b0;
    #1 pwrup_rst_n = 1'b0;

    // power-up: 17 edges of reset after release
    tick(5);
    chk("rst_rst_n", 32'(seq_if.rst_n), 32'd0);
    chk("rst_cause", 32'(seq_if.rst_cause), 32'd0);
    chk("rst_btn", 32'(seq_if.btn_stable), 32'd1);
    pwrup_rst_n = 1'b1;
    tick(16);
    chk("pu_edge16", 32'(seq_if.rst_n), 32'd0);
    tick(1);
    chk("pu_edge17", 32'(seq_if.rst_n), 32'd1);
    chk("pu_cause", 32'(seq_if.rst_cause), 32'd0);

    // 5-cycle glitch must be filtered
    seq_if.reset = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) seq_if.reset = 1'b1;
      tick(1);
      if (seq_if.rst_n !== 1'b1 || seq_if.btn_stable !== 1'b1) saw_low = 1'b1;
    end
    chk("glitch_filtered", 32'(saw_low), 32'd0);

    // 20-cycle press: falls 11 edges after press, rises 27 edges after release
    seq_if.reset = 1'b0;
    tick(10);
    chk("press_btn_e10", 32'(seq_if.btn_stable), 32'd0);
    chk("press_rst_e10", 32'(seq_if.rst_n), 32'd1);
    tick(1);
    chk("press_rst_e11", 32'(seq_if.rst_n), 32'd0);
    chk("press_cause", 32'(seq_if.rst_cause), 32'd1);
    tick(9);
    seq_if.reset = 1'b1;
    tick(10);
    chk("rel_btn_e10", 32'(seq_if.btn_stable), 32'd1);
    tick(16);
    chk("rel_rst_e26", 32'(seq_if.rst_n), 32'd0);
    tick(1);
    chk("rel_rst_e27", 32'(seq_if.rst_n), 32'd1);
    chk("rel_cause", 32'(seq_if.rst_cause), 32'd1);

    // power loss in STRETCH at cnt_st=10
    seq_if.reset = 1'b0;
    tick(20);
    seq_if.reset = 1'b1;
    tick(21);
    chk("st_cause_held", 32'(seq_if.rst_cause), 32'd1);
    chk("st_rst_n", 32'(seq_if.rst_n), 32'd0);
    #2 pwrup_rst_n = 1'b0;
    #1;
    chk("pl_rst_n", 32'(seq_if.rst_n), 32'd0);
    chk("pl_cause", 32'(seq_if.rst_cause), 32'd0);
    chk("pl_btn", 32'(seq_if.btn_stable), 32'd1);
    tick(3);
    pwrup_rst_n = 1'b1;
    tick(16);
    chk("pl_ret_e16", 32'(seq_if.rst_n), 32'd0);
    tick(1);
    chk("pl_ret_e17", 32'(seq_if.rst_n), 32'd1);
    chk("pl_ret_cause", 32'(seq_if.rst_cause), 32'd0);

`ifdef RST_SEQ_WDT_EN
    // unserviced watchdog fires on the 64th RUN edge
    tick(63);
    chk("wdt_pre", 32'(seq_if.rst_n), 32'd1);
    tick(1);
    chk("wdt_fire", 32'(seq_if.rst_n), 32'd0);
    chk("wdt_cause", 32'(seq_if.rst_cause), 32'd2);
    tick(16);
    chk("wdt_ret_e16", 32'(seq_if.rst_n), 32'd0);
    tick(1);
    chk("wdt_ret_e17", 32'(seq_if.rst_n), 32'd1);
    chk("wdt_ret_cause", 32'(seq_if.rst_cause), 32'd2);

    // kick on the timeout cycle, then periodic kicks
    tick(63);
    seq_if.wdt_kick = 1'b1;
    tick(1);
    seq_if.wdt_kick = 1'b0;
    chk("wdt_kick_same", 32'(seq_if.rst_n), 32'd1);
    saw_low = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      seq_if.wdt_kick = (i % 60 == 59);
      tick(1);
      if (seq_if.rst_n !== 1'b1) saw_low = 1'b1;
    end
    seq_if.wdt_kick = 1'b0;
    chk("wdt_kick_run", 32'(saw_low), 32'd0);
    chk("wdt_kick_cause", 32'(seq_if.rst_cause), 32'd2);
`else
    // without the watchdog, silence and stray kicks change nothing
    saw_low = 1'b0;
    saw_wdt = 1'b0;
    for (int i = 0; i < 200; i++) begin
      seq_if.wdt_kick = (i % 37 == 5);
      tick(1);
      if (seq_if.rst_n !== 1'b1) saw_low = 1'b1;
      if (seq_if.rst_cause === 2'b10) saw_wdt = 1'b1;
    end
    seq_if.wdt_kick = 1'b0;
    chk("nowdt_run", 32'(saw_low), 32'd0);
    chk("nowdt_cause10", 32'(saw_wdt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
